// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit accumulator CPU: instruction field
// positions, ALU opcodes, destination/operand-source encodings and a decoder.
package cpu_pkg;

    localparam int WIDTH = 16;

    // Instruction field bit positions
    localparam int LOAD_BIT  = 15;
    localparam int DEST_HI   = 14;
    localparam int DEST_LO   = 13;
    localparam int ASRC_BIT  = 12;
    localparam int BSRC_HI   = 11;
    localparam int BSRC_LO   = 10;
    localparam int OP_HI     = 9;
    localparam int OP_LO     = 6;
    localparam int JUMP_BIT  = 5;
    localparam int CONST_HI  = 4;
    localparam int CONST_LO  = 0;

    // ALU opcodes; 13..15 are unassigned and yield zero
    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_SUB   = 4'd1;
    localparam logic [3:0] ALU_AND   = 4'd2;
    localparam logic [3:0] ALU_OR    = 4'd3;
    localparam logic [3:0] ALU_XOR   = 4'd4;
    localparam logic [3:0] ALU_NOTA  = 4'd5;
    localparam logic [3:0] ALU_NOTB  = 4'd6;
    localparam logic [3:0] ALU_PASSA = 4'd7;
    localparam logic [3:0] ALU_PASSB = 4'd8;
    localparam logic [3:0] ALU_INCA  = 4'd9;
    localparam logic [3:0] ALU_DECA  = 4'd10;
    localparam logic [3:0] ALU_SHLA  = 4'd11;
    localparam logic [3:0] ALU_SHRA  = 4'd12;

    // Where a compute instruction sends its result
    typedef enum logic [1:0] {
        DEST_NONE = 2'b00,
        DEST_AR   = 2'b01,
        DEST_MR   = 2'b10,
        DEST_MEM  = 2'b11
    } dest_e;

    // Operand B source selector
    typedef enum logic [1:0] {
        BSRC_CONST = 2'b00,
        BSRC_AR    = 2'b01,
        BSRC_MR    = 2'b10,
        BSRC_DATA  = 2'b11
    } bsrc_e;

    // Fully decoded instruction
    typedef struct packed {
        logic             is_load;
        dest_e            dest;
        logic             a_const;
        bsrc_e            bsrc;
        logic [3:0]       op;
        logic             jump;
        logic [WIDTH-1:0] konst;
        logic [WIDTH-1:0] load_val;
    } decode_t;

    // Split an instruction word into its fields. The compute fields are
    // decoded even for constant loads because the ALU output stays visible.
    function automatic decode_t decode(input logic [WIDTH-1:0] instr);
        decode_t d;
        d.is_load  = instr[LOAD_BIT];
        d.dest     = dest_e'(instr[DEST_HI:DEST_LO]);
        d.a_const  = instr[ASRC_BIT];
        d.bsrc     = bsrc_e'(instr[BSRC_HI:BSRC_LO]);
        d.op       = instr[OP_HI:OP_LO];
        d.jump     = instr[JUMP_BIT];
        d.konst    = {{(WIDTH-CONST_HI-1){1'b0}}, instr[CONST_HI:CONST_LO]};
        d.load_val = {1'b0, instr[LOAD_BIT-1:0]};
        return d;
    endfunction

endpackage

// File: rtl/cpu_alu.sv
// Purely combinational 16-bit ALU; all arithmetic wraps modulo 2^16.
module alu
    import cpu_pkg::*;
(
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    output logic [WIDTH-1:0] y
);

    // Select the operation result; unassigned opcodes give zero
    always_comb begin
        y = '0;
        case (op)
            ALU_ADD:   y = a + b;
            ALU_SUB:   y = a - b;
            ALU_AND:   y = a & b;
            ALU_OR:    y = a | b;
            ALU_XOR:   y = a ^ b;
            ALU_NOTA:  y = ~a;
            ALU_NOTB:  y = ~b;
            ALU_PASSA: y = a;
            ALU_PASSB: y = b;
            ALU_INCA:  y = a + 16'd1;
            ALU_DECA:  y = a - 16'd1;
            ALU_SHLA:  y = {a[WIDTH-2:0], 1'b0};
            ALU_SHRA:  y = {1'b0, a[WIDTH-1:1]};
            default:   y = '0;
        endcase
    end

endmodule

// File: rtl/cpu.sv
// Single-cycle 16-bit accumulator CPU: decoder, operand muxes, AR/MR/PC
// registers and next-PC logic. Memories are external and read combinationally.
module cpu
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] instr,
    input  logic [15:0] data,
    output logic        write,
    output logic [15:0] dataAddr,
    output logic [15:0] instrAddr,
    output logic [15:0] result
);

    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] ar;
    logic [WIDTH-1:0] mr;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic [WIDTH-1:0] alu_y;
    logic [WIDTH-1:0] pc_next;
    logic             take_jump;
    logic             ld_ar;
    logic             ld_mr;
    decode_t          dec;

    assign dec = decode(instr);

    // Operand A: accumulator or the zero-extended immediate
    always_comb begin
        opa = dec.a_const ? dec.konst : ar;
    end

    // Operand B: immediate, AR, MR or the data-memory read value
    always_comb begin
        opb = dec.konst;
        case (dec.bsrc)
            BSRC_CONST: opb = dec.konst;
            BSRC_AR:    opb = ar;
            BSRC_MR:    opb = mr;
            BSRC_DATA:  opb = data;
            default:    opb = dec.konst;
        endcase
    end

    alu u_alu (
        .a  (opa),
        .b  (opb),
        .op (dec.op),
        .y  (alu_y)
    );

    // The jump target is the MR value held before the edge, so an
    // instruction that both loads MR and jumps lands at the old MR.
    assign take_jump = !dec.is_load && dec.jump && (alu_y == '0);
    assign pc_next   = take_jump ? mr : pc + 16'd1;

    // Register load enables; loads are suppressed while reset is held
    assign ld_ar = !reset && !dec.is_load && (dec.dest == DEST_AR);
    assign ld_mr = !reset && (dec.is_load || (dec.dest == DEST_MR));

    // Program counter: cleared asynchronously, otherwise advances or jumps
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc <= '0;
        end else begin
            pc <= pc_next;
        end
    end

    // AR and MR are deliberately not reset; they keep their contents
    always_ff @(posedge clk) begin
        if (ld_ar) begin
            ar <= alu_y;
        end
        if (ld_mr) begin
            mr <= dec.is_load ? dec.load_val : alu_y;
        end
    end

    assign result    = alu_y;
    assign write     = !reset && !dec.is_load && (dec.dest == DEST_MEM);
    assign dataAddr  = mr;
    assign instrAddr = pc;

endmodule

// File: tb/tb_cpu.sv
// Self-checking bench for the accumulator CPU: directed scenarios followed by
// randomized instruction streams checked against a behavioural model.
module tb_cpu;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] instr;
    logic [15:0] data;
    logic        write;
    logic [15:0] dataAddr;
    logic [15:0] instrAddr;
    logic [15:0] result;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model state
    logic [15:0] m_pc = 16'h0000;
    logic [15:0] m_ar;
    logic [15:0] m_mr;

    cpu dut (
        .clk       (clk),
        .reset     (reset),
        .instr     (instr),
        .data      (data),
        .write     (write),
        .dataAddr  (dataAddr),
        .instrAddr (instrAddr),
        .result    (result)
    );

    // Clock generation
    always #5 clk = ~clk;

    // Watchdog
    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
        $fatal(1, "timeout");
    end

    // ALU behaviour expressed with plain integer arithmetic modulo 65536
    function automatic logic [15:0] ref_result(input logic [15:0] i, input logic [15:0] d);
        int unsigned a;
        int unsigned b;
        int unsigned y;
        a = i[12] ? int'(i[4:0]) : int'(m_ar);
        case (i[11:10])
            2'd0:    b = int'(i[4:0]);
            2'd1:    b = int'(m_ar);
            2'd2:    b = int'(m_mr);
            default: b = int'(d);
        endcase
        case (int'(i[9:6]))
            0:  y = a + b;
            1:  y = a + 65536 - b;
            2:  y = a & b;
            3:  y = a | b;
            4:  y = a ^ b;
            5:  y = 65535 - a;
            6:  y = 65535 - b;
            7:  y = a;
            8:  y = b;
            9:  y = a + 1;
            10: y = a + 65535;
            11: y = a * 2;
            12: y = a / 2;
            default: y = 0;
        endcase
        y = y % 65536;
        return y[15:0];
    endfunction

    function automatic logic ref_write(input logic [15:0] i);
        return !reset && !i[15] && (i[14:13] == 2'b11);
    endfunction

    // Advance the model by one instruction using pre-edge state
    task automatic model_step(input logic [15:0] i, input logic [15:0] d);
        logic [15:0] r;
        logic [15:0] old_mr;
        r = ref_result(i, d);
        old_mr = m_mr;
        if (reset) begin
            m_pc = 16'h0000;
        end else if (i[15]) begin
            m_mr = {1'b0, i[14:0]};
            m_pc = m_pc + 16'd1;
        end else begin
            if (i[14:13] == 2'b01) m_ar = r;
            if (i[14:13] == 2'b10) m_mr = r;
            if (i[5] && r == 16'h0000) m_pc = old_mr;
            else m_pc = m_pc + 16'd1;
        end
    endtask

    // Present inputs and wait to the sampling point (falling edge)
    task automatic apply(input logic [15:0] i, input logic [15:0] d);
        instr = i;
        data  = d;
        @(negedge clk);
    endtask

    // Clock the current instruction into both DUT and model
    task automatic tick();
        model_step(instr, data);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        instr = 16'h80FF;
        data  = 16'h0000;
        #2;
        n_checks++;
        if (instrAddr !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_instrAddr: got %h expected 0000", instrAddr);
        end
        instr = 16'h7800;
        #1;
        n_checks++;
        if (write !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_write: got %b expected 0", write);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (instrAddr !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_hold_pc: got %h expected 0000", instrAddr);
        end
        reset = 1'b0;
        m_pc = 16'h0000;
    endtask

    task automatic test_load();
        apply(16'h80FF, 16'h0000);
        n_checks++;
        if (instrAddr !== 16'h0000) begin
            n_fail++;
            $display("FAIL load_pre_pc: got %h expected 0000", instrAddr);
        end
        tick();
        n_checks++;
        if (dataAddr !== 16'h00FF) begin
            n_fail++;
            $display("FAIL load_mr: got %h expected 00ff", dataAddr);
        end
        n_checks++;
        if (instrAddr !== 16'h0001) begin
            n_fail++;
            $display("FAIL load_pc: got %h expected 0001", instrAddr);
        end
    endtask

    task automatic test_load_ar();
        apply(16'h3C01, 16'h0000);
        n_checks++;
        if (result !== 16'h0001) begin
            n_fail++;
            $display("FAIL load_ar_result: got %h expected 0001", result);
        end
        n_checks++;
        if (write !== 1'b0) begin
            n_fail++;
            $display("FAIL load_ar_write: got %b expected 0", write);
        end
        tick();
        n_checks++;
        if (instrAddr !== 16'h0002) begin
            n_fail++;
            $display("FAIL load_ar_pc: got %h expected 0002", instrAddr);
        end
    endtask

    task automatic test_store();
        apply(16'h4000, 16'h0000);
        tick();
        n_checks++;
        if (dataAddr !== 16'h0001) begin
            n_fail++;
            $display("FAIL copy_ar_mr: got %h expected 0001", dataAddr);
        end
        apply(16'h7800, 16'h0000);
        n_checks++;
        if (write !== 1'b1) begin
            n_fail++;
            $display("FAIL store_write: got %b expected 1", write);
        end
        n_checks++;
        if (result !== 16'h0001) begin
            n_fail++;
            $display("FAIL store_result: got %h expected 0001", result);
        end
        n_checks++;
        if (dataAddr !== 16'h0001) begin
            n_fail++;
            $display("FAIL store_addr: got %h expected 0001", dataAddr);
        end
        tick();
    endtask

    task automatic test_jump();
        apply(16'h1020, 16'h0000);
        n_checks++;
        if (result !== 16'h0000) begin
            n_fail++;
            $display("FAIL jump_result: got %h expected 0000", result);
        end
        tick();
        n_checks++;
        if (instrAddr !== 16'h0001) begin
            n_fail++;
            $display("FAIL jump_target: got %h expected 0001", instrAddr);
        end
        apply(16'h1000, 16'h0000);
        n_checks++;
        if (write !== 1'b0) begin
            n_fail++;
            $display("FAIL nop_write: got %b expected 0", write);
        end
        tick();
        n_checks++;
        if (instrAddr !== 16'h0002) begin
            n_fail++;
            $display("FAIL nop_pc: got %h expected 0002", instrAddr);
        end
    endtask

    task automatic test_no_jump();
        apply(16'h31C3, 16'h0000);   // AR <= 3
        tick();
        apply(16'h0023, 16'h0000);   // AR + 3 = 6, jump bit set
        n_checks++;
        if (result !== 16'h0006) begin
            n_fail++;
            $display("FAIL no_jump_result: got %h expected 0006", result);
        end
        tick();
        n_checks++;
        if (instrAddr !== 16'h0004) begin
            n_fail++;
            $display("FAIL no_jump_pc: got %h expected 0004", instrAddr);
        end
    endtask

    task automatic test_async_reset();
        int guard;
        guard = 0;
        while (instrAddr !== 16'h0005 && guard < 8) begin
            apply(16'h1000, 16'h0000);
            tick();
            guard++;
        end
        n_checks++;
        if (instrAddr !== 16'h0005) begin
            n_fail++;
            $display("FAIL reach_pc5: got %h expected 0005", instrAddr);
        end
        apply(16'h7800, 16'h0000);
        n_checks++;
        if (write !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset_write: got %b expected 1", write);
        end
        #2;
        reset = 1'b1;
        m_pc  = 16'h0000;
        #1;
        n_checks++;
        if (instrAddr !== 16'h0000) begin
            n_fail++;
            $display("FAIL async_pc_clear: got %h expected 0000", instrAddr);
        end
        n_checks++;
        if (write !== 1'b0) begin
            n_fail++;
            $display("FAIL async_write: got %b expected 0", write);
        end
        n_checks++;
        if (dataAddr !== 16'h0001) begin
            n_fail++;
            $display("FAIL async_mr_kept: got %h expected 0001", dataAddr);
        end
        // Loads to AR and MR must be ignored while reset is held
        instr = 16'h3C01;
        data  = 16'h1234;
        tick();
        instr = 16'h5C01;
        tick();
        n_checks++;
        if (instrAddr !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_pc_hold: got %h expected 0000", instrAddr);
        end
        n_checks++;
        if (dataAddr !== 16'h0001) begin
            n_fail++;
            $display("FAIL reset_mr_hold: got %h expected 0001", dataAddr);
        end
        reset = 1'b0;
        apply(16'h01C0, 16'h0000);   // result = AR
        n_checks++;
        if (result !== 16'h0003) begin
            n_fail++;
            $display("FAIL reset_ar_hold: got %h expected 0003", result);
        end
        n_checks++;
        if (instrAddr !== 16'h0000) begin
            n_fail++;
            $display("FAIL first_fetch: got %h expected 0000", instrAddr);
        end
        tick();
        n_checks++;
        if (instrAddr !== 16'h0001) begin
            n_fail++;
            $display("FAIL post_release_pc: got %h expected 0001", instrAddr);
        end
    endtask

    task automatic test_alu_sweep();
        logic [15:0] i;
        logic [15:0] exp_r;
        for (int op = 0; op < 16; op++) begin
            apply(16'h2E00, 16'($urandom));   // AR <= data
            tick();
            i = 16'h0C00 | 16'(op << 6);      // result = op(AR, data)
            apply(i, 16'($urandom));
            exp_r = ref_result(instr, data);
            n_checks++;
            if (result !== exp_r) begin
                n_fail++;
                $display("FAIL alu_op%0d: a=%h b=%h got %h expected %h", op, m_ar, data, result, exp_r);
            end
            tick();
        end
    endtask

    task automatic test_random();
        logic [15:0] exp_r;
        for (int n = 0; n < 400; n++) begin
            if (reset) begin
                reset = 1'b0;
            end else if ($urandom_range(0, 24) == 0) begin
                reset = 1'b1;
                m_pc  = 16'h0000;
            end
            apply(16'($urandom), 16'($urandom));
            exp_r = ref_result(instr, data);
            n_checks++;
            if (result !== exp_r) begin
                n_fail++;
                $display("FAIL rand_result[%0d]: instr=%h got %h expected %h", n, instr, result, exp_r);
            end
            n_checks++;
            if (write !== ref_write(instr)) begin
                n_fail++;
                $display("FAIL rand_write[%0d]: instr=%h got %b expected %b", n, instr, write, ref_write(instr));
            end
            n_checks++;
            if (instrAddr !== m_pc) begin
                n_fail++;
                $display("FAIL rand_pc[%0d]: got %h expected %h", n, instrAddr, m_pc);
            end
            n_checks++;
            if (dataAddr !== m_mr) begin
                n_fail++;
                $display("FAIL rand_mr[%0d]: got %h expected %h", n, dataAddr, m_mr);
            end
            tick();
        end
        reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_load();
        test_load_ar();
        test_store();
        test_jump();
        test_no_jump();
        test_async_reset();
        test_alu_sweep();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
